// File: rtl/gpu_fbuf_pkg.sv
// Shared framebuffer geometry, requester indices and fill-engine state encoding.
package gpu_fbuf_pkg;

    localparam int FB_WIDTH    = 640;
    localparam int FB_HEIGHT   = 480;
    localparam int COORD_WIDTH = 10;

    // Requester slots on the framebuffer write arbiter
    localparam int REQ_PIX  = 0;
    localparam int REQ_FILL = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/fbuf_wr_arbiter.sv
// Two-way round-robin arbiter in front of the framebuffer BRAM write port,
// with a registered output stage (grant in cycle n drives the port in n+1).
module fbuf_wr_arbiter #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       s_axi_ctrl_aclk,
    input  logic                       s_axi_ctrl_aresetn,
    input  logic [1:0]                 req,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] req_data,
    output logic [1:0]                 gnt,
    output logic                       wr_en,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [DATA_WIDTH-1:0]      wr_data
);
    import gpu_fbuf_pkg::*;

    logic                  last_fill_reg;
    logic                  wr_en_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  sel;

    // On a tie the requester that did not win last time is served
    always_comb begin
        gnt = req;
        if (req[REQ_PIX] && req[REQ_FILL]) begin
            gnt[REQ_PIX]  = last_fill_reg;
            gnt[REQ_FILL] = !last_fill_reg;
        end
    end

    assign sel = gnt[REQ_FILL];

    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) begin
            last_fill_reg <= 1'b1;
            wr_en_reg     <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
        end else begin
            wr_en_reg <= |gnt;
            if (|gnt) begin
                last_fill_reg <= sel;
                addr_reg      <= req_addr[sel];
                data_reg      <= req_data[sel];
            end
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_addr = addr_reg;
    assign wr_data = data_reg;

endmodule

// File: rtl/fbuf_fill_engine.sv
// Rectangle-fill sequencer for the framebuffer; shares the BRAM write port
// with single-pixel writes through fbuf_wr_arbiter.
module fbuf_fill_engine #(
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int FBUF_DATA_WIDTH = 8,
    parameter int FB_WIDTH        = gpu_fbuf_pkg::FB_WIDTH,
    parameter int FB_HEIGHT       = gpu_fbuf_pkg::FB_HEIGHT,
    parameter int COORD_WIDTH     = gpu_fbuf_pkg::COORD_WIDTH
) (
    input  logic                       s_axi_ctrl_aclk,
    input  logic                       s_axi_ctrl_aresetn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [COORD_WIDTH-1:0]     cmd_x0,
    input  logic [COORD_WIDTH-1:0]     cmd_y0,
    input  logic [COORD_WIDTH-1:0]     cmd_w,
    input  logic [COORD_WIDTH-1:0]     cmd_h,
    input  logic [FBUF_DATA_WIDTH-1:0] cmd_color,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic [FBUF_ADDR_WIDTH-1:0] pix_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] pix_data,
    output logic                       fbuf_en_wr,
    output logic                       fbuf_wrea,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    output logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
    output logic                       busy,
    output logic                       done,
    output logic                       done_empty
);
    import gpu_fbuf_pkg::*;

    localparam logic [COORD_WIDTH:0]       FBW_C = (COORD_WIDTH+1)'(FB_WIDTH);
    localparam logic [COORD_WIDTH:0]       FBH_C = (COORD_WIDTH+1)'(FB_HEIGHT);
    localparam logic [FBUF_ADDR_WIDTH-1:0] FBW_A = FBUF_ADDR_WIDTH'(FB_WIDTH);

    fill_state_t state_reg, state_next;
    logic        active_reg;

    logic [COORD_WIDTH-1:0]     x0_reg, y0_reg, w_reg, h_reg;
    logic [FBUF_DATA_WIDTH-1:0] color_reg;
    logic [COORD_WIDTH:0]       x_reg, y_reg, x_end_reg, y_end_reg;
    logic [FBUF_ADDR_WIDTH-1:0] row_base_reg, addr_reg;
    logic                       empty_reg;

    logic [COORD_WIDTH:0]       x_sum, y_sum, x_end_c, y_end_c;
    logic [FBUF_ADDR_WIDTH-1:0] row_base_c;
    logic                       setup_empty, row_last, last_pixel;
    logic                       fill_req, fill_gnt, pix_req;

    logic [1:0]                      arb_req, arb_gnt;
    logic [1:0][FBUF_ADDR_WIDTH-1:0] arb_addr;
    logic [1:0][FBUF_DATA_WIDTH-1:0] arb_data;

    // Keeps cmd_ready and pixel grants low until the first clock after reset
    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) active_reg <= 1'b0;
        else                     active_reg <= 1'b1;
    end

    assign x_sum       = {1'b0, x0_reg} + {1'b0, w_reg};
    assign y_sum       = {1'b0, y0_reg} + {1'b0, h_reg};
    assign x_end_c     = (x_sum > FBW_C) ? FBW_C : x_sum;
    assign y_end_c     = (y_sum > FBH_C) ? FBH_C : y_sum;
    assign row_base_c  = FBUF_ADDR_WIDTH'(y0_reg) * FBW_A;
    assign setup_empty = ({1'b0, x0_reg} >= x_end_c) || ({1'b0, y0_reg} >= y_end_c);
    assign row_last    = (x_reg == x_end_reg - 1'b1);
    assign last_pixel  = row_last && (y_reg == y_end_reg - 1'b1);

    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) state_reg <= ST_IDLE;
        else                     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (cmd_valid && cmd_ready) state_next = ST_SETUP;
            ST_SETUP: state_next = setup_empty ? ST_DONE : ST_FILL;
            ST_FILL:  if (fill_gnt && last_pixel) state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_reg == ST_IDLE) && active_reg;
        busy       = (state_reg != ST_IDLE);
        done       = (state_reg == ST_DONE);
        done_empty = (state_reg == ST_DONE) && empty_reg;
        fill_req   = (state_reg == ST_FILL);
    end

    // Multiply once per command; the fill loop walks addresses incrementally
    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) begin
            x0_reg       <= '0;
            y0_reg       <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            color_reg    <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            x_end_reg    <= '0;
            y_end_reg    <= '0;
            row_base_reg <= '0;
            addr_reg     <= '0;
            empty_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (cmd_valid && cmd_ready) begin
                    x0_reg    <= cmd_x0;
                    y0_reg    <= cmd_y0;
                    w_reg     <= cmd_w;
                    h_reg     <= cmd_h;
                    color_reg <= cmd_color;
                end
                ST_SETUP: begin
                    x_end_reg    <= x_end_c;
                    y_end_reg    <= y_end_c;
                    x_reg        <= {1'b0, x0_reg};
                    y_reg        <= {1'b0, y0_reg};
                    row_base_reg <= row_base_c;
                    addr_reg     <= row_base_c + FBUF_ADDR_WIDTH'(x0_reg);
                    empty_reg    <= setup_empty;
                end
                ST_FILL: if (fill_gnt) begin
                    if (row_last) begin
                        x_reg        <= {1'b0, x0_reg};
                        y_reg        <= y_reg + 1'b1;
                        row_base_reg <= row_base_reg + FBW_A;
                        addr_reg     <= row_base_reg + FBW_A + FBUF_ADDR_WIDTH'(x0_reg);
                    end else begin
                        x_reg    <= x_reg + 1'b1;
                        addr_reg <= addr_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_req = pix_valid && active_reg;

    always_comb begin
        arb_req            = '0;
        arb_addr           = '0;
        arb_data           = '0;
        arb_req[REQ_PIX]   = pix_req;
        arb_addr[REQ_PIX]  = pix_addr;
        arb_data[REQ_PIX]  = pix_data;
        arb_req[REQ_FILL]  = fill_req;
        arb_addr[REQ_FILL] = addr_reg;
        arb_data[REQ_FILL] = color_reg;
    end

    fbuf_wr_arbiter #(
        .ADDR_WIDTH (FBUF_ADDR_WIDTH),
        .DATA_WIDTH (FBUF_DATA_WIDTH)
    ) u_arb (
        .s_axi_ctrl_aclk    (s_axi_ctrl_aclk),
        .s_axi_ctrl_aresetn (s_axi_ctrl_aresetn),
        .req                (arb_req),
        .req_addr           (arb_addr),
        .req_data           (arb_data),
        .gnt                (arb_gnt),
        .wr_en              (fbuf_en_wr),
        .wr_addr            (fbuf_addr),
        .wr_data            (fbuf_data)
    );

    assign fill_gnt  = arb_gnt[REQ_FILL];
    assign pix_ready = arb_gnt[REQ_PIX];
    assign fbuf_wrea = fbuf_en_wr;

endmodule

// File: tb/tb_fbuf_fill_engine.sv
// Self-checking bench for fbuf_fill_engine: directed and random fill commands
// checked cycle by cycle against a rectangle/arbitration reference model.
module tb_fbuf_fill_engine;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int CW = 10;

    logic          s_axi_ctrl_aclk = 1'b0;
    logic          s_axi_ctrl_aresetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [DW-1:0] cmd_color;
    logic          pix_valid;
    logic          pix_ready;
    logic [AW-1:0] pix_addr;
    logic [DW-1:0] pix_data;
    logic          fbuf_en_wr, fbuf_wrea;
    logic [AW-1:0] fbuf_addr;
    logic [DW-1:0] fbuf_data;
    logic          busy, done, done_empty;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    always #5 s_axi_ctrl_aclk = ~s_axi_ctrl_aclk;

    fbuf_fill_engine dut (
        .s_axi_ctrl_aclk    (s_axi_ctrl_aclk),
        .s_axi_ctrl_aresetn (s_axi_ctrl_aresetn),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_x0             (cmd_x0),
        .cmd_y0             (cmd_y0),
        .cmd_w              (cmd_w),
        .cmd_h              (cmd_h),
        .cmd_color          (cmd_color),
        .pix_valid          (pix_valid),
        .pix_ready          (pix_ready),
        .pix_addr           (pix_addr),
        .pix_data           (pix_data),
        .fbuf_en_wr         (fbuf_en_wr),
        .fbuf_wrea          (fbuf_wrea),
        .fbuf_addr          (fbuf_addr),
        .fbuf_data          (fbuf_data),
        .busy               (busy),
        .done               (done),
        .done_empty         (done_empty)
    );

    // Issues one command from a negedge with cmd_ready high and checks every
    // cycle through the first idle cycle after done.
    task automatic do_cmd(input int x0, input int y0, input int w, input int h,
                          input logic [DW-1:0] color, input bit pix, input string name);
        int n, dcyc, errs0;
        errs0 = errors;
        exp_q.delete();
        for (int y = y0; y < y0 + h && y < 480; y++)
            for (int x = x0; x < x0 + w && x < 640; x++)
                exp_q.push_back(y * 640 + x);
        n = exp_q.size();
        // Under contention the fill wins every other cycle starting in cycle 2
        dcyc = (n == 0) ? 2 : (pix ? 2 * n + 1 : n + 2);

        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cmd_ready_c0 got=%b want=1", name, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_x0    = CW'(x0);
        cmd_y0    = CW'(y0);
        cmd_w     = CW'(w);
        cmd_h     = CW'(h);
        cmd_color = color;
        pix_valid = pix;
        pix_addr  = AW'('h100);
        pix_data  = 8'hFF;
        @(posedge s_axi_ctrl_aclk);

        for (int k = 1; k <= dcyc + 1; k++) begin
            bit   fw;
            int   fi;
            logic want_en, want_pr;
            @(negedge s_axi_ctrl_aclk);
            fw = 1'b0;
            fi = 0;
            if (n > 0) begin
                if (pix) begin
                    if ((k % 2 == 1) && k >= 3 && k <= 2 * n + 1) begin fw = 1'b1; fi = (k - 3) / 2; end
                end else if (k >= 3 && k <= n + 2) begin
                    fw = 1'b1; fi = k - 3;
                end
            end
            want_en = fw || pix;
            want_pr = pix && !(n > 0 && (k % 2 == 0) && k >= 2 && k <= 2 * n);

            checks++;
            if (fbuf_en_wr !== want_en) begin
                errors++; $display("FAIL %s en c%0d got=%b want=%b", name, k, fbuf_en_wr, want_en);
            end
            checks++;
            if (fbuf_wrea !== want_en) begin
                errors++; $display("FAIL %s wrea c%0d got=%b want=%b", name, k, fbuf_wrea, want_en);
            end
            if (fw) begin
                checks++;
                if (fbuf_addr !== AW'(exp_q[fi])) begin
                    errors++; $display("FAIL %s addr c%0d got=%0d want=%0d", name, k, fbuf_addr, exp_q[fi]);
                end
                checks++;
                if (fbuf_data !== color) begin
                    errors++; $display("FAIL %s data c%0d got=%h want=%h", name, k, fbuf_data, color);
                end
            end else if (pix) begin
                checks++;
                if (fbuf_addr !== AW'('h100) || fbuf_data !== 8'hFF) begin
                    errors++; $display("FAIL %s pixwr c%0d got=%h/%h want=100/ff", name, k, fbuf_addr, fbuf_data);
                end
            end
            checks++;
            if (pix_ready !== want_pr) begin
                errors++; $display("FAIL %s pix_ready c%0d got=%b want=%b", name, k, pix_ready, want_pr);
            end
            checks++;
            if (done !== (k == dcyc) || done_empty !== (k == dcyc && n == 0)) begin
                errors++; $display("FAIL %s done c%0d got=%b/%b want=%b/%b", name, k, done, done_empty,
                                   (k == dcyc), (k == dcyc && n == 0));
            end
            checks++;
            if (busy !== (k <= dcyc) || cmd_ready !== (k == dcyc + 1)) begin
                errors++; $display("FAIL %s busy/ready c%0d got=%b/%b want=%b/%b", name, k, busy, cmd_ready,
                                   (k <= dcyc), (k == dcyc + 1));
            end

            // Junk command held while busy must be ignored
            if (k == 1) begin
                cmd_x0    = CW'($urandom);
                cmd_y0    = CW'($urandom);
                cmd_w     = CW'($urandom);
                cmd_h     = CW'($urandom);
                cmd_color = DW'($urandom);
            end
            if (k == dcyc) cmd_valid = 1'b0;
        end
        pix_valid = 1'b0;
        $display("cmd %s x0=%0d y0=%0d w=%0d h=%0d color=%h pix=%0d pixels=%0d done_cycle=%0d errors=%0d",
                 name, x0, y0, w, h, color, pix, n, dcyc, errors - errs0);
    endtask

    task automatic test_reset();
        s_axi_ctrl_aresetn = 1'b0;
        cmd_valid = 1'b1;
        pix_valid = 1'b1;
        repeat (3) @(negedge s_axi_ctrl_aclk);
        checks++;
        if (cmd_ready !== 1'b0 || pix_ready !== 1'b0) begin
            errors++; $display("FAIL reset ready got=%b/%b want=0/0", cmd_ready, pix_ready);
        end
        checks++;
        if (fbuf_en_wr !== 1'b0 || fbuf_wrea !== 1'b0) begin
            errors++; $display("FAIL reset en got=%b/%b want=0/0", fbuf_en_wr, fbuf_wrea);
        end
        checks++;
        if (fbuf_addr !== '0 || fbuf_data !== '0) begin
            errors++; $display("FAIL reset addr/data got=%h/%h want=0/0", fbuf_addr, fbuf_data);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || done_empty !== 1'b0) begin
            errors++; $display("FAIL reset status got=%b%b%b want=000", busy, done, done_empty);
        end
        cmd_valid = 1'b0;
        pix_valid = 1'b0;
        s_axi_ctrl_aresetn = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset ready_at_release got=%b want=0", cmd_ready);
        end
        @(negedge s_axi_ctrl_aclk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset ready_after got=%b/%b want=1/0", cmd_ready, busy);
        end
        $display("reset released, cmd_ready=%b", cmd_ready);
    endtask

    task automatic test_basic();
        do_cmd(2, 1, 3, 2, 8'h5A, 1'b0, "basic");
    endtask

    task automatic test_clip();
        do_cmd(638, 479, 5, 5, 8'hC3, 1'b0, "clip");
    endtask

    task automatic test_empty();
        do_cmd(10, 10, 0, 4, 8'h11, 1'b0, "empty_w0");
        do_cmd(640, 10, 4, 4, 8'h22, 1'b0, "empty_x640");
        do_cmd(10, 480, 4, 4, 8'h23, 1'b0, "empty_y480");
    endtask

    task automatic test_contention();
        do_cmd(10, 20, 3, 2, 8'h77, 1'b1, "contention");
    endtask

    task automatic test_async_reset();
        cmd_valid = 1'b1;
        cmd_x0 = 10'd5; cmd_y0 = 10'd3; cmd_w = 10'd4; cmd_h = 10'd2; cmd_color = 8'h33;
        @(posedge s_axi_ctrl_aclk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge s_axi_ctrl_aclk);
            cmd_valid = 1'b0;
        end
        checks++;
        if (fbuf_en_wr !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL arst pre en/busy got=%b/%b want=1/1", fbuf_en_wr, busy);
        end
        #2 s_axi_ctrl_aresetn = 1'b0;
        #1;
        checks++;
        if (fbuf_en_wr !== 1'b0 || fbuf_wrea !== 1'b0 || fbuf_addr !== '0) begin
            errors++; $display("FAIL arst en/wrea/addr got=%b/%b/%0d want=0/0/0", fbuf_en_wr, fbuf_wrea, fbuf_addr);
        end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL arst busy/ready/done got=%b/%b/%b want=0/0/0", busy, cmd_ready, done);
        end
        @(negedge s_axi_ctrl_aclk);
        s_axi_ctrl_aresetn = 1'b1;
        @(negedge s_axi_ctrl_aclk);
        $display("async reset mid-fill applied and released");
        do_cmd(100, 200, 4, 3, 8'h9C, 1'b0, "after_arst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int x0, y0, w, h;
            x0 = ($urandom_range(0, 1) == 1) ? 628 + $urandom_range(0, 14) : $urandom_range(0, 639);
            y0 = ($urandom_range(0, 1) == 1) ? 474 + $urandom_range(0, 8)  : $urandom_range(0, 479);
            w  = $urandom_range(0, 9);
            h  = $urandom_range(0, 4);
            do_cmd(x0, y0, w, h, DW'($urandom), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axi_ctrl_aresetn = 1'b0;
        cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        pix_valid = 1'b0;
        pix_addr = '0;
        pix_data = '0;
        test_reset();
        test_basic();
        test_clip();
        test_empty();
        test_contention();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
